spi_slave_wishbone: RTL and testbench
=====================================

SPI_SLAVE_WISHBONE -- requirements
Module: spi_slave_wishbone

Interface
REQ-001 Parameter SYNC_STAGES, 2, flip-flop depth of the sck/cs/mosi synchronizers (minimum 2).
REQ-002 Parameter DUMMY_BYTE, 8'hFF, byte shifted out when no transmit data is available.
REQ-003 CLK_I  input  1  single system clock; all state changes on its rising edge.
REQ-004 RST_I  input  1  reset, asynchronous and active-high.
REQ-005 STB_I  input  1  bus strobe.
REQ-006 WE_I  input  1  write enable, qualified by STB_I.
REQ-007 ADR_I  input  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 reserved.
REQ-008 DAT_I  input  8  bus write data.
REQ-009 DAT_O  output  8  bus read data, valid while ACK_O=1.
REQ-010 ACK_O  output  1  single-cycle bus acknowledge.
REQ-011 IRQ_O  output  1  registered interrupt request.
REQ-012 sck  input  1  SPI clock from the external master, asynchronous to CLK_I.
REQ-013 cs  input  1  SPI chip select, active low, asynchronous.
REQ-014 mosi  input  1  serial data from the master.
REQ-015 miso  output  1  serial data to the master.
REQ-016 miso_oe  output  1  miso drive enable; 1 only while the block is selected.

Function
REQ-017 sck, cs and mosi shall each pass through SYNC_STAGES flops; sck edges shall be detected on the synchronized signal. Supported sck high and low times are each >= SYNC_STAGES+1 CLK_I periods.
REQ-018 SPI mode 0, MSB first, 8-bit frames: mosi is sampled on sck rising, miso changes on sck falling.
REQ-019 FSM states: IDLE (cs_sync=1) and SHIFT (cs_sync=0). IDLE->SHIFT on cs_sync falling; SHIFT->IDLE on cs_sync rising; a 3-bit bit counter resets to 0 on entry to SHIFT.
REQ-020 On IDLE->SHIFT, tx_shift shall load from the TX holding register and set TX_EMPTY=1. If TX_EMPTY was already 1, it shall load DUMMY_BYTE and set UNDERRUN.
REQ-021 miso shall equal tx_shift[7] in SHIFT and 0 in IDLE; miso_oe shall equal ~cs_sync.
REQ-022 Each sck rising in SHIFT shall shift mosi into rx_shift and increment the counter, which wraps 7->0.
REQ-023 Each sck falling in SHIFT with counter != 0 shall shift tx_shift left by one; a falling edge with counter == 0 shall not shift.
REQ-024 On the 8th rising edge (counter wrap), tx_shift shall reload as in REQ-020, enabling back-to-back bytes without deselect.
REQ-025 On a completed byte, if RX_FULL=0, RXDATA takes the byte and RX_FULL is set. If RX_FULL=1, OVERRUN is set and RXDATA is left unchanged.
REQ-026 If cs_sync rises mid-byte, the partial byte shall be discarded: no RX update and no flag change. A holding byte already loaded into tx_shift is consumed.
REQ-027 Bus: ACK_O <= STB_I & ~ACK_O. Register effects occur in the cycle ACK_O is asserted, so each strobe gets exactly one ACK pulse.
REQ-028 A write to DATA loads the TX holding register and clears TX_EMPTY; a write while TX_EMPTY=0 overwrites without any flag.
REQ-029 A read of DATA returns RXDATA and clears RX_FULL.
REQ-030 STATUS read: bit0 RX_FULL, bit1 TX_EMPTY, bit2 OVERRUN, bit3 BUSY (cs_sync=0), bit4 UNDERRUN, bits7:5 zero. A STATUS write with bit2 or bit4 set clears that flag (write-1-to-clear).
REQ-031 CTRL is read/write: bit0 RXIE, bit1 TXIE, bit2 ERRIE; bits7:3 read 0. Reads of address 3 return 0; writes to it are ignored.
REQ-032 IRQ_O <= (RXIE&RX_FULL) | (TXIE&TX_EMPTY) | (ERRIE&(OVERRUN|UNDERRUN)).
REQ-033 Byte completion in the same cycle as a DATA read: the read returns the old RXDATA, the new byte is stored, RX_FULL stays 1, and OVERRUN is not set.
REQ-034 A tx_shift load in the same cycle as a DATA write: the load uses the pre-write holding value (or DUMMY_BYTE if empty), then the written byte is stored and TX_EMPTY=0.
REQ-035 A flag-set event in the same cycle as its W1C clear: the set wins.

Reset
REQ-036 While RST_I=1, all of the following shall hold: DAT_O=0, ACK_O=0, IRQ_O=0, miso=0, miso_oe=0, FSM=IDLE, counter=0, shift registers=0, RXDATA=0, holding=0, CTRL=0, RX_FULL=0, OVERRUN=0, UNDERRUN=0, TX_EMPTY=1.
REQ-037 Synchronizer flops shall reset to the idle bus level (sck=0, cs=1, mosi=0); a transfer in progress at reset is abandoned.

Verification
REQ-038 Write DATA=8'hA5; master sends 8'h3C in one frame -> miso carries A5 MSB-first, RXDATA=3C, RX_FULL=1, TX_EMPTY=1.
REQ-039 No TX write; master clocks one byte -> miso carries 8'hFF and STATUS reads 8'h1B while cs is low (RX_FULL, TX_EMPTY, BUSY, UNDERRUN).
REQ-040 Two back-to-back bytes 11, 22 without reading DATA -> RXDATA=11 and OVERRUN=1; STATUS write 8'h04 -> OVERRUN=0.
REQ-041 cs deasserted after 5 sck edges -> RX_FULL stays 0 and the next full frame is received correctly.
REQ-042 CTRL=8'h01; a byte arrives -> IRQ_O=1; DATA read -> IRQ_O=0 two cycles later.
REQ-043 RST_I pulsed mid-frame asynchronously -> all outputs reach their reset values without waiting for a CLK_I edge.

Source files
------------

// File: rtl/spi_slave_wishbone_if.sv
// Register bus between a bus master and the SPI slave: strobe, write enable,
// 2-bit register select, 8-bit data both ways, acknowledge and interrupt.
interface spi_slave_wishbone_if;
  logic       STB_I;
  logic       WE_I;
  logic [1:0] ADR_I;
  logic [7:0] DAT_I;
  logic [7:0] DAT_O;
  logic       ACK_O;
  logic       IRQ_O;

  modport slave (
    input  STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O, IRQ_O
  );

  modport master (
    output STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O, IRQ_O
  );
endinterface

// File: rtl/spi_slave_wishbone.sv
// SPI mode-0 slave (MSB first, 8-bit frames) with a small register bank
// (DATA / STATUS / CTRL) on a single-cycle-acknowledge bus.
// Bus handshake: a strobe with ACK_O low is an access; it is acknowledged by
// ACK_O=1 for exactly one cycle, DAT_O is valid in that cycle, and all
// register side effects land on the same clock edge that raises ACK_O.
// The master must drop STB_I after seeing ACK_O or it will start a new access.
module spi_slave_wishbone #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DUMMY_BYTE  = 8'hFF
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  spi_slave_wishbone_if.slave  wb,
  input  logic                 sck,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic                 dbg_state
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [SYNC_STAGES-1:0] sck_q, cs_q, mosi_q;
  logic       sck_s, cs_s, mosi_s, sck_d;
  logic       sck_rise, sck_fall;
  state_t     state, next_state;
  logic       start, shift_in, shift_out, byte_done, load_tx;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift, rx_byte;
  logic [7:0] rx_data, tx_hold, rd_mux;
  logic [2:0] ctrl;
  logic       rx_full, tx_empty, overrun, underrun;
  logic       access, wr, rd;

  assign sck_s    = sck_q[SYNC_STAGES-1];
  assign cs_s     = cs_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign rx_byte  = {rx_shift[6:0], mosi_s};

  // Synchronizers reset to the idle bus level so reset never looks like a select
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      sck_q  <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
      sck_d  <= 1'b0;
    end else begin
      sck_q  <= {sck_q[SYNC_STAGES-2:0], sck};
      cs_q   <= {cs_q[SYNC_STAGES-2:0], cs};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_d  <= sck_s;
    end
  end

  // FSM state register
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and per-cycle shift controls; sck edges only count while selected
  always_comb begin
    next_state = state;
    start      = 1'b0;
    shift_in   = 1'b0;
    shift_out  = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          next_state = IDLE;
        end else begin
          shift_in  = sck_rise;
          shift_out = sck_fall && (bit_cnt != 3'd0);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign byte_done = shift_in && (bit_cnt == 3'd7);
  assign load_tx   = start || byte_done;

  // Shift datapath; the fall right after a reload is skipped so the new MSB holds
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 8'd0;
      tx_shift <= 8'd0;
    end else begin
      if (start)         bit_cnt <= 3'd0;
      else if (shift_in) bit_cnt <= bit_cnt + 3'd1;
      if (shift_in) rx_shift <= rx_byte;
      if (load_tx)        tx_shift <= tx_empty ? DUMMY_BYTE : tx_hold;
      else if (shift_out) tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign miso      = (state == SHIFT) ? tx_shift[7] : 1'b0;
  assign miso_oe   = ~cs_s;
  assign dbg_state = state;

  assign access = wb.STB_I & ~wb.ACK_O;
  assign wr     = access & wb.WE_I;
  assign rd     = access & ~wb.WE_I;

  // Register read mux
  always_comb begin
    rd_mux = 8'd0;
    case (wb.ADR_I)
      2'd0:    rd_mux = rx_data;
      2'd1:    rd_mux = {3'd0, underrun, ~cs_s, overrun, tx_empty, rx_full};
      2'd2:    rd_mux = {5'd0, ctrl};
      default: rd_mux = 8'd0;
    endcase
  end

  // Bus registers and flags; set events are applied after clears so sets win
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wb.ACK_O <= 1'b0;
      wb.DAT_O <= 8'd0;
      wb.IRQ_O <= 1'b0;
      rx_data  <= 8'd0;
      tx_hold  <= 8'd0;
      ctrl     <= 3'd0;
      rx_full  <= 1'b0;
      tx_empty <= 1'b1;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      wb.ACK_O <= access;
      wb.DAT_O <= rd ? rd_mux : 8'd0;
      wb.IRQ_O <= (ctrl[0] & rx_full) | (ctrl[1] & tx_empty) |
                  (ctrl[2] & (overrun | underrun));

      if (wr && wb.ADR_I == 2'd2) ctrl <= wb.DAT_I[2:0];

      if (wr && wb.ADR_I == 2'd1 && wb.DAT_I[2]) overrun  <= 1'b0;
      if (wr && wb.ADR_I == 2'd1 && wb.DAT_I[4]) underrun <= 1'b0;
      if (rd && wb.ADR_I == 2'd0)                rx_full  <= 1'b0;

      // Transmit side: a load consumes the holding byte before a same-cycle write
      if (load_tx) begin
        tx_empty <= 1'b1;
        if (tx_empty) underrun <= 1'b1;
      end
      if (wr && wb.ADR_I == 2'd0) begin
        tx_hold  <= wb.DAT_I;
        tx_empty <= 1'b0;
      end

      // Receive side: a same-cycle DATA read frees the slot for the new byte
      if (byte_done) begin
        if (!rx_full || (rd && wb.ADR_I == 2'd0)) begin
          rx_data <= rx_byte;
          rx_full <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_wishbone.sv
// Directed bench for spi_slave_wishbone: a register-access vector table
// followed by hand-written SPI frame sequences.
module tb_spi_slave_wishbone;

  localparam int HALF = 8;

  logic CLK_I = 1'b0;
  logic RST_I = 1'b1;
  logic sck = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, dbg_state;

  int n_vec = 0;
  int n_err = 0;

  spi_slave_wishbone_if wb();

  spi_slave_wishbone #(.SYNC_STAGES(2), .DUMMY_BYTE(8'hFF)) dut (
    .CLK_I    (CLK_I),
    .RST_I    (RST_I),
    .wb       (wb),
    .sck      (sck),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic       we;
    logic [1:0] adr;
    logic [7:0] wdat;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic bus_access(input logic we, input logic [1:0] adr,
                            input logic [7:0] wdat, output logic [7:0] rdat);
    bit got = 0;
    rdat = 8'h00;
    @(negedge CLK_I);
    wb.STB_I = 1'b1;
    wb.WE_I  = we;
    wb.ADR_I = adr;
    wb.DAT_I = wdat;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge CLK_I);
      #1;
      if (wb.ACK_O) begin
        got  = 1;
        rdat = wb.DAT_O;
      end
    end
    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: got no ACK_O expected ACK_O within 10 cycles");
    end
  endtask

  task automatic bus_write(input logic [1:0] adr, input logic [7:0] wdat);
    logic [7:0] dummy;
    bus_access(1'b1, adr, wdat, dummy);
  endtask

  task automatic bus_read_check(input string name, input logic [1:0] adr, input logic [7:0] exp);
    logic [7:0] r;
    bus_access(1'b0, adr, 8'h00, r);
    check(name, r, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  task automatic cs_assert();
    @(negedge CLK_I);
    cs = 1'b0;
    wait_cycles(12);
  endtask

  task automatic cs_release();
    wait_cycles(HALF);
    cs = 1'b1;
    wait_cycles(12);
  endtask

  // Mode 0 master: drive mosi while sck low, sample miso just before sck rises
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_cycles(HALF);
      rx[i] = miso;
      sck = 1'b1;
      wait_cycles(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  initial begin
    logic [7:0] rx, rx2;

    vecs[0]  = '{1'b0, 2'd1, 8'h00, 8'h02, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 2'd2, 8'hFF, 8'h00, 1'b1};
    vecs[4]  = '{1'b0, 2'd2, 8'h00, 8'h07, 1'b1};
    vecs[5]  = '{1'b1, 2'd3, 8'h55, 8'h00, 1'b1};
    vecs[6]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 2'd0, 8'h12, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 2'd1, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};

    wb.STB_I = 1'b0;
    wb.WE_I  = 1'b0;
    wb.ADR_I = 2'd0;
    wb.DAT_I = 8'h00;

    // reset values while RST_I is held
    wait_cycles(3);
    check("rst_dat_o", wb.DAT_O, 8'h00);
    check("rst_ack_o", {7'd0, wb.ACK_O}, 8'h00);
    check("rst_irq_o", {7'd0, wb.IRQ_O}, 8'h00);
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_state", {7'd0, dbg_state}, 8'h00);
    RST_I = 1'b0;
    wait_cycles(4);

    // register table
    for (int i = 0; i < 11; i++) begin
      logic [7:0] r;
      bus_access(vecs[i].we, vecs[i].adr, vecs[i].wdat, r);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      wait_cycles(2);
      check($sformatf("vec%0d_irq", i), {7'd0, wb.IRQ_O}, {7'd0, vecs[i].exp_irq});
    end

    // basic frame: holding A5 goes out while 3C comes in
    bus_write(2'd0, 8'hA5);
    cs_assert();
    spi_byte(8'h3C, rx);
    cs_release();
    check("a_miso", rx, 8'hA5);
    bus_read_check("a_status", 2'd1, 8'h13);
    bus_read_check("a_data", 2'd0, 8'h3C);
    bus_write(2'd1, 8'h10);
    bus_read_check("a_status2", 2'd1, 8'h02);

    // no transmit data: dummy byte and underrun, status read while selected
    cs_assert();
    check("b_miso_oe", {7'd0, miso_oe}, 8'h01);
    check("b_state", {7'd0, dbg_state}, 8'h01);
    spi_byte(8'h5A, rx);
    check("b_miso", rx, 8'hFF);
    bus_read_check("b_status_busy", 2'd1, 8'h1B);
    cs_release();
    check("b_miso_oe_off", {7'd0, miso_oe}, 8'h00);
    bus_read_check("b_data", 2'd0, 8'h5A);
    bus_write(2'd1, 8'h10);
    bus_read_check("b_status2", 2'd1, 8'h02);

    // back-to-back bytes without reading DATA: overrun, first byte kept
    bus_write(2'd0, 8'h81);
    cs_assert();
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx2);
    cs_release();
    check("c_miso0", rx, 8'h81);
    check("c_miso1", rx2, 8'hFF);
    bus_read_check("c_status", 2'd1, 8'h17);
    bus_read_check("c_data", 2'd0, 8'h11);
    bus_write(2'd1, 8'h04);
    bus_read_check("c_status_w1c_ovr", 2'd1, 8'h12);
    bus_write(2'd1, 8'h10);
    bus_read_check("c_status_w1c_und", 2'd1, 8'h02);

    // aborted partial byte, then a clean full frame
    cs_assert();
    spi_bits(8'hE0, 3, rx);
    cs_release();
    bus_read_check("d_status_partial", 2'd1, 8'h12);
    bus_write(2'd1, 8'h10);
    bus_write(2'd0, 8'hC3);
    cs_assert();
    spi_byte(8'h96, rx);
    cs_release();
    check("d_miso", rx, 8'hC3);
    bus_read_check("d_data", 2'd0, 8'h96);
    bus_read_check("d_status", 2'd1, 8'h12);
    bus_write(2'd1, 8'h10);

    // receive interrupt raised by a byte, dropped by the DATA read
    bus_write(2'd2, 8'h01);
    wait_cycles(2);
    check("e_irq_idle", {7'd0, wb.IRQ_O}, 8'h00);
    cs_assert();
    spi_byte(8'h77, rx);
    cs_release();
    check("e_irq_set", {7'd0, wb.IRQ_O}, 8'h01);
    bus_read_check("e_data", 2'd0, 8'h77);
    check("e_irq_at_ack", {7'd0, wb.IRQ_O}, 8'h01);
    @(posedge CLK_I);
    #1;
    check("e_irq_clr", {7'd0, wb.IRQ_O}, 8'h00);
    bus_write(2'd1, 8'h10);
    bus_write(2'd2, 8'h00);

    // asynchronous reset in the middle of a frame
    bus_write(2'd2, 8'h02);
    wait_cycles(2);
    check("f_irq_pre", {7'd0, wb.IRQ_O}, 8'h01);
    cs_assert();
    spi_bits(8'hA0, 2, rx);
    check("f_miso_oe_pre", {7'd0, miso_oe}, 8'h01);
    @(posedge CLK_I);
    #2;
    RST_I = 1'b1;
    #1;
    check("f_rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    check("f_rst_miso", {7'd0, miso}, 8'h00);
    check("f_rst_state", {7'd0, dbg_state}, 8'h00);
    check("f_rst_irq", {7'd0, wb.IRQ_O}, 8'h00);
    check("f_rst_ack", {7'd0, wb.ACK_O}, 8'h00);
    check("f_rst_dat", wb.DAT_O, 8'h00);
    cs   = 1'b1;
    sck  = 1'b0;
    mosi = 1'b0;
    wait_cycles(3);
    RST_I = 1'b0;
    wait_cycles(4);
    bus_read_check("f_status", 2'd1, 8'h02);
    bus_read_check("f_ctrl", 2'd2, 8'h00);
    bus_read_check("f_data", 2'd0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
